// File: rtl/pagerank_pkg.sv
// Shared types and constants for the PageRank streamer and compute stage.
//   dmp_state_t : streamer FSM states
//   edge_t      : one edge-list entry {src, dst}, zero-extended to a fixed width
//   FP_ZERO     : float64 +0.0, used for empty lanes
//   MAX_ITERATIONS : iteration cap agreed with the compute stage
package pagerank_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StFetch,
    StPack,
    StEmit,
    StWaitAck
  } dmp_state_t;

  // Fixed 16-bit fields so the type does not depend on the graph size parameter.
  typedef struct packed {
    logic [15:0] src;
    logic [15:0] dst;
  } edge_t;

  localparam logic [63:0] FP_ZERO = 64'h0000_0000_0000_0000;

  localparam int unsigned MAX_ITERATIONS = 100;

endpackage

// File: rtl/dmp_lane_packer.sv
// Lane vector and occupancy mask for one outgoing beat.
//   clock_i, reset_i : clock, synchronous active-high reset
//   clr_i            : empty all lanes and the mask (priority over write)
//   wr_en_i          : write data_i into lane_i and mark it occupied
//   lane_i, data_i   : target lane and float64 value
//   lanes_o          : packed lane vector, lane k at [64*k +: 64]
//   collision_o      : lane_i is already occupied in this beat
module dmp_lane_packer
  import pagerank_pkg::*;
#(
  parameter int unsigned NODES_IN_GRAPH = 32,
  localparam int unsigned NODE_W = $clog2(NODES_IN_GRAPH)
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic                         clr_i,
  input  logic                         wr_en_i,
  input  logic [NODE_W-1:0]            lane_i,
  input  logic [63:0]                  data_i,
  output logic [64*NODES_IN_GRAPH-1:0] lanes_o,
  output logic                         collision_o
);

  logic [64*NODES_IN_GRAPH-1:0] lanes_d, lanes_q;
  logic [NODES_IN_GRAPH-1:0]    mask_d, mask_q;

  always_comb begin
    lanes_d = lanes_q;
    mask_d  = mask_q;
    if (clr_i) begin
      lanes_d = {NODES_IN_GRAPH{FP_ZERO}};
      mask_d  = '0;
    end else if (wr_en_i) begin
      lanes_d[64*lane_i +: 64] = data_i;
      mask_d[lane_i]           = 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      lanes_q <= {NODES_IN_GRAPH{FP_ZERO}};
      mask_q  <= '0;
    end else begin
      lanes_q <= lanes_d;
      mask_q  <= mask_d;
    end
  end

  assign lanes_o     = lanes_q;
  assign collision_o = mask_q[lane_i];

endmodule

// File: rtl/pagerank_dmp_streamer.sv
// Walks the edge list once per iteration and scatters each source's contribution onto the
// destination lane of a stream beat, packing up to EDGES_PER_BEAT collision-free edges.
//   start_i/num_edges_i/contrib_i : iteration request, edge count, per-source contributions
//   edge_rd_en_o/edge_addr_o/edge_rd_data_i : edge memory port, data one cycle after strobe
//   pagerank_serial_stream_o, stream_start_o/valid_o/ready_i/done_o : beat stream to compute
//   ack_i : compute stage finished; busy_o, edge_error_o, beat_count_o : status
module pagerank_dmp_streamer
  import pagerank_pkg::*;
#(
  parameter int unsigned NODES_IN_GRAPH = 32,
  parameter int unsigned MAX_EDGES      = 1024,
  parameter int unsigned EDGES_PER_BEAT = 4,
  localparam int unsigned NODE_W = $clog2(NODES_IN_GRAPH),
  localparam int unsigned AW     = $clog2(MAX_EDGES),
  localparam int unsigned CW     = $clog2(EDGES_PER_BEAT + 1)
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic                         start_i,
  input  logic [AW:0]                  num_edges_i,
  input  logic [64*NODES_IN_GRAPH-1:0] contrib_i,
  output logic                         edge_rd_en_o,
  output logic [AW-1:0]                edge_addr_o,
  input  logic [2*NODE_W-1:0]          edge_rd_data_i,
  output logic [64*NODES_IN_GRAPH-1:0] pagerank_serial_stream_o,
  output logic                         stream_start_o,
  output logic                         stream_valid_o,
  input  logic                         stream_ready_i,
  output logic                         stream_done_o,
  input  logic                         ack_i,
  output logic                         busy_o,
  output logic                         edge_error_o,
  output logic [31:0]                  beat_count_o
);

  dmp_state_t  state_d, state_q;
  logic [AW:0] num_edges_d, num_edges_q;
  logic [AW:0] edge_ptr_d, edge_ptr_q;
  logic [CW-1:0] packed_d, packed_q;
  logic        final_d, final_q;
  logic        edge_error_d, edge_error_q;
  logic [31:0] beat_count_d, beat_count_q;

  logic        pk_clr, pk_wr, pk_collision;
  edge_t       rd_edge;
  logic        edge_oob;
  logic [AW:0] ptr_inc;
  logic [CW-1:0] packed_inc;

  assign rd_edge.src = 16'(edge_rd_data_i[2*NODE_W-1:NODE_W]);
  assign rd_edge.dst = 16'(edge_rd_data_i[NODE_W-1:0]);
  // Can only fire for a non-power-of-two lane count; kept so such builds stay safe.
  assign edge_oob   = (rd_edge.src >= 16'(NODES_IN_GRAPH)) || (rd_edge.dst >= 16'(NODES_IN_GRAPH));
  assign ptr_inc    = edge_ptr_q + 1'b1;
  assign packed_inc = packed_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    num_edges_d  = num_edges_q;
    edge_ptr_d   = edge_ptr_q;
    packed_d     = packed_q;
    final_d      = final_q;
    edge_error_d = edge_error_q;
    beat_count_d = beat_count_q;
    pk_clr       = 1'b0;
    pk_wr        = 1'b0;
    edge_rd_en_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          num_edges_d  = num_edges_i;
          edge_ptr_d   = '0;
          packed_d     = '0;
          final_d      = 1'b0;
          edge_error_d = 1'b0;
          beat_count_d = '0;
          pk_clr       = 1'b1;
          state_d      = StStart;
        end
      end
      StStart: state_d = StFetch;
      StFetch: begin
        if (edge_ptr_q < num_edges_q) begin
          edge_rd_en_o = 1'b1;
          state_d      = StPack;
        end else begin
          final_d = 1'b1;
          state_d = StEmit;
        end
      end
      StPack: begin
        if (edge_oob) begin
          edge_error_d = 1'b1;
          edge_ptr_d   = ptr_inc;
          state_d      = StFetch;
        end else if (pk_collision) begin
          // Leave the edge unconsumed; it is refetched into the next beat.
          final_d = 1'b0;
          state_d = StEmit;
        end else begin
          pk_wr      = 1'b1;
          edge_ptr_d = ptr_inc;
          packed_d   = packed_inc;
          if (packed_inc == CW'(EDGES_PER_BEAT) || ptr_inc == num_edges_q) begin
            final_d = (ptr_inc == num_edges_q);
            state_d = StEmit;
          end else begin
            state_d = StFetch;
          end
        end
      end
      StEmit: begin
        if (stream_ready_i) begin
          beat_count_d = beat_count_q + 32'd1;
          pk_clr       = 1'b1;
          packed_d     = '0;
          state_d      = final_q ? StWaitAck : StFetch;
        end
      end
      StWaitAck: begin
        if (ack_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      num_edges_q  <= '0;
      edge_ptr_q   <= '0;
      packed_q     <= '0;
      final_q      <= 1'b0;
      edge_error_q <= 1'b0;
      beat_count_q <= '0;
    end else begin
      state_q      <= state_d;
      num_edges_q  <= num_edges_d;
      edge_ptr_q   <= edge_ptr_d;
      packed_q     <= packed_d;
      final_q      <= final_d;
      edge_error_q <= edge_error_d;
      beat_count_q <= beat_count_d;
    end
  end

  dmp_lane_packer #(
    .NODES_IN_GRAPH(NODES_IN_GRAPH)
  ) u_packer (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .clr_i      (pk_clr),
    .wr_en_i    (pk_wr),
    .lane_i     (rd_edge.dst[NODE_W-1:0]),
    .data_i     (contrib_i[64*rd_edge.src[NODE_W-1:0] +: 64]),
    .lanes_o    (pagerank_serial_stream_o),
    .collision_o(pk_collision)
  );

  assign edge_addr_o    = edge_ptr_q[AW-1:0];
  assign stream_start_o = (state_q == StStart);
  assign stream_valid_o = (state_q == StEmit);
  assign stream_done_o  = (state_q == StEmit) && final_q;
  assign busy_o         = (state_q != StIdle);
  assign edge_error_o   = edge_error_q;
  assign beat_count_o   = beat_count_q;

endmodule

// File: tb/tb_pagerank_dmp_streamer.sv
module tb_pagerank_dmp_streamer;

  localparam int N = 32;

  logic            clock = 1'b0;
  logic            reset, start, stream_ready, ack;
  logic [10:0]     num_edges;
  logic [64*N-1:0] contrib;
  logic            edge_rd_en;
  logic [9:0]      edge_addr;
  logic [9:0]      edge_rd_data;
  logic [64*N-1:0] vec;
  logic            stream_start, stream_valid, stream_done, busy, edge_error;
  logic [31:0]     beat_count;

  logic [9:0] mem [1024];

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  // Edge memory: data appears one cycle after the read strobe.
  always @(posedge clock) if (edge_rd_en) edge_rd_data <= mem[edge_addr];

  pagerank_dmp_streamer dut (
    .clock_i                 (clock),
    .reset_i                 (reset),
    .start_i                 (start),
    .num_edges_i             (num_edges),
    .contrib_i               (contrib),
    .edge_rd_en_o            (edge_rd_en),
    .edge_addr_o             (edge_addr),
    .edge_rd_data_i          (edge_rd_data),
    .pagerank_serial_stream_o(vec),
    .stream_start_o          (stream_start),
    .stream_valid_o          (stream_valid),
    .stream_ready_i          (stream_ready),
    .stream_done_o           (stream_done),
    .ack_i                   (ack),
    .busy_o                  (busy),
    .edge_error_o            (edge_error),
    .beat_count_o            (beat_count)
  );

  typedef struct {
    int nedges;
    int stall;
    int nbeats;
    int nreads;
    int nz[3];
  } scen_t;

  typedef struct {
    int          scen;
    int          beat;
    int          lane;
    logic [63:0] val;
  } lane_exp_t;

  scen_t     sc[5];
  lane_exp_t lt[17];

  logic [64*N-1:0] cap [4];
  logic            cap_done [4];
  int nb, reads, extra_starts, first_addr, stall_seen, stall_bad;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int nonzero_lanes(input logic [64*N-1:0] v);
    int c = 0;
    for (int i = 0; i < N; i++) if (v[64*i +: 64] != 64'd0) c++;
    return c;
  endfunction

  task automatic set_edge(input int i, input int s, input int d);
    mem[i] = {5'(s), 5'(d)};
  endtask

  task automatic load_scen(input int s);
    case (s)
      0, 3: begin set_edge(0, 0, 1); set_edge(1, 2, 3); set_edge(2, 4, 5); end
      1: begin set_edge(0, 0, 2); set_edge(1, 1, 2); end
      2: for (int k = 0; k < 9; k++) set_edge(k, k, k + 10);
      default: ;
    endcase
  endtask

  task automatic run_iter(input int n, input int stall);
    bit fin = 0;
    int stall_left = stall;
    bit have_snap = 0;
    logic [64*N-1:0] snap;
    logic snap_done;
    nb = 0; reads = 0; extra_starts = 0; first_addr = -1; stall_seen = 0; stall_bad = 0;
    num_edges    = 11'(n);
    stream_ready = (stall == 0);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("start_pulse", 64'(stream_start), 64'd1);
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      @(negedge clock);
      if (edge_rd_en) begin
        if (reads == 0) first_addr = int'(edge_addr);
        reads++;
      end
      if (stream_start) extra_starts++;
      if (stream_valid) begin
        if (stall_left > 0) begin
          if (!have_snap) begin
            snap = vec; snap_done = stream_done; have_snap = 1;
          end else if (vec !== snap || stream_done !== snap_done) begin
            stall_bad++;
          end
          stall_seen++;
          stall_left--;
          stream_ready = 1'b0;
        end else begin
          stream_ready = 1'b1;
          if (nb < 4) begin
            cap[nb] = vec; cap_done[nb] = stream_done;
          end
          nb++;
          if (stream_done) fin = 1;
        end
      end
    end
    check("iter_finished", 64'(fin), 64'd1);
  endtask

  task automatic finish_iter(input int nbeats);
    @(negedge clock);
    check("wait_ack_busy", 64'(busy), 64'd1);
    check("wait_ack_no_valid", 64'(stream_valid), 64'd0);
    check("beat_count", 64'(beat_count), 64'(nbeats));
    repeat (3) @(negedge clock);
    check("still_busy_no_ack", 64'(busy), 64'd1);
    ack = 1'b1;
    @(negedge clock);
    ack = 1'b0;
    check("idle_after_ack", 64'(busy), 64'd0);
  endtask

  initial begin
    sc[0] = '{nedges: 3, stall: 0, nbeats: 1, nreads: 3, nz: '{3, 0, 0}};
    sc[1] = '{nedges: 2, stall: 0, nbeats: 2, nreads: 3, nz: '{1, 1, 0}};
    sc[2] = '{nedges: 9, stall: 0, nbeats: 3, nreads: 9, nz: '{4, 4, 1}};
    sc[3] = '{nedges: 3, stall: 5, nbeats: 1, nreads: 3, nz: '{3, 0, 0}};
    sc[4] = '{nedges: 0, stall: 0, nbeats: 1, nreads: 0, nz: '{0, 0, 0}};
    lt[0]  = '{0, 0, 1,  64'h3FF0_0000_0000_0000};
    lt[1]  = '{0, 0, 3,  64'h4008_0000_0000_0000};
    lt[2]  = '{0, 0, 5,  64'h4014_0000_0000_0000};
    lt[3]  = '{1, 0, 2,  64'h3FF0_0000_0000_0000};
    lt[4]  = '{1, 1, 2,  64'h4000_0000_0000_0000};
    lt[5]  = '{2, 0, 10, 64'h3FF0_0000_0000_0000};
    lt[6]  = '{2, 0, 11, 64'h4000_0000_0000_0000};
    lt[7]  = '{2, 0, 12, 64'h4008_0000_0000_0000};
    lt[8]  = '{2, 0, 13, 64'h4010_0000_0000_0000};
    lt[9]  = '{2, 1, 14, 64'h4014_0000_0000_0000};
    lt[10] = '{2, 1, 15, 64'h4018_0000_0000_0000};
    lt[11] = '{2, 1, 16, 64'h401C_0000_0000_0000};
    lt[12] = '{2, 1, 17, 64'h4020_0000_0000_0000};
    lt[13] = '{2, 2, 18, 64'h4022_0000_0000_0000};
    lt[14] = '{3, 0, 1,  64'h3FF0_0000_0000_0000};
    lt[15] = '{3, 0, 3,  64'h4008_0000_0000_0000};
    lt[16] = '{3, 0, 5,  64'h4014_0000_0000_0000};

    for (int k = 0; k < N; k++) contrib[64*k +: 64] = $realtobits(real'(k + 1));
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    reset = 1'b1; start = 1'b0; ack = 1'b0; stream_ready = 1'b1; num_edges = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(stream_valid), 64'd0);
    check("rst_start", 64'(stream_start), 64'd0);
    check("rst_done", 64'(stream_done), 64'd0);
    check("rst_rd_en", 64'(edge_rd_en), 64'd0);
    check("rst_err", 64'(edge_error), 64'd0);
    check("rst_beats", 64'(beat_count), 64'd0);
    check("rst_vec_nz", 64'(nonzero_lanes(vec)), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    for (int s = 0; s < 5; s++) begin
      load_scen(s);
      run_iter(sc[s].nedges, sc[s].stall);
      check($sformatf("s%0d_extra_starts", s), 64'(extra_starts), 64'd0);
      check($sformatf("s%0d_beats", s), 64'(nb), 64'(sc[s].nbeats));
      check($sformatf("s%0d_reads", s), 64'(reads), 64'(sc[s].nreads));
      check($sformatf("s%0d_edge_error", s), 64'(edge_error), 64'd0);
      for (int b = 0; b < nb && b < 3; b++) begin
        check($sformatf("s%0d_b%0d_done", s, b), 64'(cap_done[b]), 64'(b == sc[s].nbeats - 1));
        check($sformatf("s%0d_b%0d_nz", s, b), 64'(nonzero_lanes(cap[b])), 64'(sc[s].nz[b]));
      end
      for (int i = 0; i < 17; i++) begin
        if (lt[i].scen == s && lt[i].beat < nb)
          check($sformatf("s%0d_b%0d_lane%0d", s, lt[i].beat, lt[i].lane),
                cap[lt[i].beat][64*lt[i].lane +: 64], lt[i].val);
      end
      if (sc[s].stall > 0) begin
        check("stall_cycles", 64'(stall_seen), 64'(sc[s].stall));
        check("stall_stable", 64'(stall_bad), 64'd0);
      end
      finish_iter(sc[s].nbeats);
    end

    // Reset while the second edge is in PACK, then a fresh iteration.
    load_scen(0);
    num_edges = 11'd3;
    stream_ready = 1'b1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    reads = 0;
    for (int cyc = 0; cyc < 50 && reads < 2; cyc++) begin
      @(negedge clock);
      if (edge_rd_en) reads++;
    end
    check("pre_reset_reads", 64'(reads), 64'd2);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_valid", 64'(stream_valid), 64'd0);
    check("mid_rst_done", 64'(stream_done), 64'd0);
    check("mid_rst_rd_en", 64'(edge_rd_en), 64'd0);
    check("mid_rst_addr", 64'(edge_addr), 64'd0);
    check("mid_rst_vec_nz", 64'(nonzero_lanes(vec)), 64'd0);
    check("mid_rst_beats", 64'(beat_count), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    load_scen(1);
    run_iter(2, 0);
    check("post_rst_first_addr", 64'(first_addr), 64'd0);
    check("post_rst_beats", 64'(nb), 64'd2);
    check("post_rst_err", 64'(edge_error), 64'd0);
    finish_iter(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pagerank_dmp_streamer.md
Name: pagerank_dmp_streamer

Overview:
- Upstream feeder for the serial PageRank compute stage. Once per iteration it walks the graph edge list from an edge memory.
- For each edge it scatters the source node's precomputed contribution (float64, pagerank[src]/outdegree[src]) onto the destination's lane of a NODES_IN_GRAPH-wide stream vector.
- It packs as many collision-free edges per beat as allowed, then hands beats to the compute stage with a valid/ready handshake and signals start/done.

Parameters:
- NODES_IN_GRAPH, 32: nodes in the graph partition (lanes per beat); power of two, at least 2.
- MAX_EDGES, 1024: edge memory depth.
- EDGES_PER_BEAT, 4: maximum edges packed into one beat (1..NODES_IN_GRAPH).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin an iteration; sampled in IDLE only (driven by compute stage nextIteration or host).
- num_edges  in  $clog2(MAX_EDGES)+1  edge count for this iteration; latched on start.
- contrib  in  64 x NODES_IN_GRAPH  per-source contribution, float64; held stable while busy.
- edge_rd_en  out  1  edge memory read strobe.
- edge_addr  out  $clog2(MAX_EDGES)  edge memory address.
- edge_rd_data  in  2*NODE_W  {src,dst}; valid exactly 1 cycle after edge_rd_en.
- pagerank_serial_stream  out  64 x NODES_IN_GRAPH  beat vector; unused lanes are 64'd0.
- stream_start  out  1  one-cycle pulse before the first beat of an iteration.
- stream_valid  out  1  beat present.
- stream_ready  in  1  compute stage accepts the beat.
- stream_done  out  1  high with the last beat of the iteration.
- ack  in  1  compute stage finished the iteration.
- busy  out  1  not in IDLE.
- edge_error  out  1  sticky; at least one edge was dropped for out-of-range src/dst; cleared on start.
- beat_count  out  32  beats accepted this iteration.

Behaviour:
- NODE_W = $clog2(NODES_IN_GRAPH).
- Reset (synchronous, active-high) forces state IDLE and clears every output: stream vector 0, all strobes 0, busy 0, edge_error 0, beat_count 0. A reset mid-iteration abandons the iteration with no partial beat or done.
- State machine: IDLE -> START -> FETCH -> PACK -> (FETCH | EMIT) -> ... -> WAIT_ACK -> IDLE.
- IDLE: on start, latch num_edges, clear edge_ptr, lane_mask, beat_count and edge_error; go to START. start outside IDLE is ignored.
- START: assert stream_start for one cycle; go to FETCH.
- FETCH: if edge_ptr < num_edges, assert edge_rd_en with edge_addr = edge_ptr and go to PACK. Otherwise go to EMIT with the final flag set.
- PACK (read data valid):
  - If src or dst is at least NODES_IN_GRAPH (only possible for a non-power-of-two, so reserve the check), drop the edge, set edge_error, increment edge_ptr, return to FETCH.
  - If lane_mask[dst] is already set, go to EMIT without consuming the edge; edge_ptr is unchanged and the edge is refetched after the beat.
  - Otherwise write lane[dst] = contrib[src], set lane_mask[dst], increment edge_ptr and the packed count.
  - If packed count == EDGES_PER_BEAT or edge_ptr == num_edges, go to EMIT (final when edge_ptr == num_edges). Otherwise go to FETCH.
- EMIT: stream_valid = 1. Vector and stream_done (= final) are held stable until stream_ready.
  - On valid && ready: increment beat_count, clear lanes and lane_mask.
  - Then go to WAIT_ACK if final, else FETCH.
- num_edges == 0: emit exactly one all-zero beat with stream_done = 1, so the compute stage still terminates.
- WAIT_ACK: busy stays 1; wait indefinitely for ack, then go to IDLE. ack in any other state is ignored.
- Latency: a full beat of E edges takes 2E cycles (FETCH+PACK per edge), plus 1 EMIT cycle when ready is high.

Decomposition:
- Shared package pagerank_pkg holds:
  - the state enum `dmp_state_t`;
  - the `edge_t` struct {src, dst};
  - the float64 constant FP_ZERO;
  - the iteration-cap constant shared with the compute stage.
- One natural sub-module: `dmp_lane_packer`, which holds the lane vector and occupancy mask, performs write/clear, and reports the collision flag.

Test Plan:
- num_edges=3, edges (0->1),(2->3),(4->5), contrib[k]=k+1.0, ready tied 1 -> one beat: lane1=1.0, lane3=3.0, lane5=5.0, others 0; stream_done=1; beat_count=1; then WAIT_ACK until ack.
- Edges (0->2),(1->2), EDGES_PER_BEAT=4 -> collision gives two beats: lane2=contrib[0], then lane2=contrib[1] with done; edge (1->2) read twice.
- num_edges=9, distinct dsts, EDGES_PER_BEAT=4 -> beats of 4, 4, 1 edges; done only on the third beat; beat_count=3.
- stream_ready held low 5 cycles during EMIT -> vector, valid and done stable all 5 cycles; no further edge_rd_en.
- num_edges=0 -> stream_start pulse, then one zero beat with done; edge_rd_en never asserted.
- reset asserted mid-PACK, then start again -> all outputs 0 the cycle after reset; new iteration starts at edge_addr 0 and edge_error is clear.
